// File: rtl/fib_capture_pkg.sv
// Shared constants for the Fibonacci capture block: register offsets,
// register bit positions and default geometry.
package fib_capture_pkg;

    localparam int unsigned DEF_WIDTH = 30;
    localparam int unsigned DEF_DEPTH = 8;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int unsigned ST_COUNT_W = 5;
    localparam int unsigned ST_EMPTY   = 8;
    localparam int unsigned ST_FULL    = 9;
    localparam int unsigned ST_OVF     = 10;
    localparam int unsigned ST_WRAP    = 11;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_CLR     = 2;
    localparam int unsigned CTRL_THR_LSB = 4;
    localparam int unsigned CTRL_THR_W   = 4;

endpackage

// File: rtl/fib_fifo.sv
// Small synchronous FIFO; the head is read combinationally from the array.
module fib_fifo
    import fib_capture_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fib_capture.sv
// Captures each settled Fibonacci value into a FIFO drained over a Wishbone
// window, with a fill-level interrupt.
module fib_capture
    import fib_capture_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100,
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned DEPTH        = DEF_DEPTH
) (
    input  logic             wb_clk_i,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]      s1;
    logic [WIDTH-1:0]      s2;
    logic [WIDTH-1:0]      last;
    logic                  enable;
    logic [CTRL_THR_W-1:0] threshold;
    logic                  ovf;
    logic                  wrap;

    logic [WIDTH-1:0]      head;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;

    logic                  hit;
    logic                  req;
    logic [1:0]            off;
    logic                  pop;
    logic                  ctrl_wr;
    logic                  flush;
    logic                  clr;
    logic                  change;
    logic                  push;
    logic [31:0]           status;
    logic [31:0]           rdata;
    logic                  unused_bits;

    assign unused_bits = ^{wbs_dat_i[31:8], wbs_dat_i[3], wbs_adr_i[1:0]};

    // Bus decode: one access accepted per ack, so a held strobe is served every 2nd cycle.
    assign hit     = (wbs_adr_i[31:4] == BASE_ADDRESS[31:4]);
    assign req     = hit && wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
    assign off     = wbs_adr_i[3:2];
    assign pop     = req && !wbs_we_i && (off == OFF_DATA);
    assign ctrl_wr = req && wbs_we_i && (off == OFF_CTRL) && (wbs_sel_i == 4'hF);
    assign flush   = ctrl_wr && wbs_dat_i[CTRL_FLUSH];
    assign clr     = ctrl_wr && wbs_dat_i[CTRL_CLR];

    // A value counts as settled once two consecutive samples agree.
    assign change  = enable && (s1 == s2) && (s2 != last);
    assign push    = change && !flush;

    always_comb begin
        status                   = '0;
        status[ST_COUNT_W-1:0]   = ST_COUNT_W'(count);
        status[ST_EMPTY]         = empty;
        status[ST_FULL]          = full;
        status[ST_OVF]           = ovf;
        status[ST_WRAP]          = wrap;
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_DATA:   rdata = empty ? '0 : 32'(head);
            OFF_STATUS: rdata = status;
            OFF_CTRL: begin
                rdata[CTRL_EN]                      = enable;
                rdata[CTRL_THR_LSB +: CTRL_THR_W]   = threshold;
            end
            default:    rdata = '0;
        endcase
    end

    fib_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (s2),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            last <= '0;
        end else begin
            s1 <= value;
            s2 <= s1;
            if (change) last <= s2;
        end
    end

    // Sticky flags: a new event in the same cycle as a clear is kept.
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            enable    <= 1'b0;
            threshold <= '0;
            ovf       <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable    <= wbs_dat_i[CTRL_EN];
                threshold <= wbs_dat_i[CTRL_THR_LSB +: CTRL_THR_W];
            end
            if (clr) begin
                ovf  <= 1'b0;
                wrap <= 1'b0;
            end
            if (push && full && !pop) ovf <= 1'b1;
            if (change && (s2 < last)) wrap <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            irq       <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            irq       <= (threshold != '0) && (ST_COUNT_W'(count) >= ST_COUNT_W'(threshold));
        end
    end

endmodule

// File: tb/tb_fib_capture.sv
// Directed bench for fib_capture: capture, FIFO limits, irq and bus rules.
module tb_fib_capture;

    localparam logic [31:0] BASE = 32'h3000_0100;

    logic        wb_clk_i = 1'b0;
    logic        reset;
    logic [29:0] value;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    fib_capture #(
        .BASE_ADDRESS (BASE),
        .WIDTH        (30),
        .DEPTH        (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .reset     (reset),
        .value     (value),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq       (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wb_read(input logic [1:0] off, output logic [31:0] d);
        bit got = 0;
        @(negedge wb_clk_i);
        wbs_adr_i = BASE + (32'(off) << 2);
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        d = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin
                got = 1;
                d   = wbs_dat_o;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL wb_read_ack off=%0d: got no ack, expected ack within 8 cycles", off);
        end
    endtask

    task automatic wb_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] sel);
        bit got = 0;
        @(negedge wb_clk_i);
        wbs_adr_i = BASE + (32'(off) << 2);
        wbs_we_i  = 1'b1;
        wbs_sel_i = sel;
        wbs_dat_i = d;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) got = 1;
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL wb_write_ack off=%0d: got no ack, expected ack within 8 cycles", off);
        end
    endtask

    task automatic set_value(input logic [29:0] v, input int cycles);
        value = v;
        repeat (cycles) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; value = '0;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        vectors++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ack=%b dat=%h irq=%b, expected 0/0/0", wbs_ack_o, wbs_dat_o, irq);
        end
        reset = 1'b0;
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h100) begin miscompares++; $display("FAIL reset_status: got %h expected %h", d, 32'h100); end
        wb_read(2'd2, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_first_capture();
        logic [31:0] d;
        wb_write(2'd2, 32'h1, 4'hF);
        value = 30'd5;
        repeat (2) @(posedge wb_clk_i);
        #1;
        vectors++;
        if (dut.u_fifo.count !== 4'd0) begin miscompares++; $display("FAIL capture_latency_early: got count %0d expected 0", dut.u_fifo.count); end
        @(posedge wb_clk_i); #1;
        vectors++;
        if (dut.u_fifo.count !== 4'd1) begin miscompares++; $display("FAIL capture_latency: got count %0d expected 1", dut.u_fifo.count); end
        wb_read(2'd0, d);
        vectors++;
        if (d !== 32'h5) begin miscompares++; $display("FAIL first_data: got %h expected %h", d, 32'h5); end
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h100) begin miscompares++; $display("FAIL first_status: got %h expected %h", d, 32'h100); end
    endtask

    task automatic test_sequence();
        logic [31:0] d;
        int vals[5] = '{1, 2, 3, 5, 8};
        foreach (vals[i]) set_value(30'(vals[i]), 4);
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h805) begin miscompares++; $display("FAIL seq_status: got %h expected %h", d, 32'h805); end
        for (int i = 0; i < 5; i++) begin
            wb_read(2'd0, d);
            vectors++;
            if (d !== 32'(vals[i])) begin miscompares++; $display("FAIL seq_data[%0d]: got %h expected %h", i, d, 32'(vals[i])); end
        end
        set_value(30'd13, 20);
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h801) begin miscompares++; $display("FAIL repeat_status: got %h expected %h", d, 32'h801); end
        wb_read(2'd0, d);
        vectors++;
        if (d !== 32'd13) begin miscompares++; $display("FAIL repeat_data: got %h expected %h", d, 32'd13); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) set_value(30'(20 + i), 4);
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'hE08) begin miscompares++; $display("FAIL ovf_status: got %h expected %h", d, 32'hE08); end
        wb_write(2'd2, 32'h5, 4'hF);
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h208) begin miscompares++; $display("FAIL ovf_cleared: got %h expected %h", d, 32'h208); end
        for (int i = 0; i < 8; i++) begin
            wb_read(2'd0, d);
            vectors++;
            if (d !== 32'(20 + i)) begin miscompares++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, d, 32'(20 + i)); end
        end
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h100) begin miscompares++; $display("FAIL ovf_drained: got %h expected %h", d, 32'h100); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        wb_write(2'd2, 32'h31, 4'hF);
        set_value(30'd30, 4);
        set_value(30'd31, 4);
        value = 30'd32;
        repeat (3) @(posedge wb_clk_i);
        #1;
        vectors++;
        if (dut.u_fifo.count !== 4'd3 || irq !== 1'b0) begin
            miscompares++; $display("FAIL irq_lag: got count=%0d irq=%b expected 3/0", dut.u_fifo.count, irq);
        end
        @(posedge wb_clk_i); #1;
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise: got %b expected 1", irq); end
        wb_read(2'd0, d);
        vectors++;
        if (d !== 32'd30) begin miscompares++; $display("FAIL irq_data: got %h expected %h", d, 32'd30); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_hold: got %b expected 1", irq); end
        @(posedge wb_clk_i); #1;
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_fall: got %b expected 0", irq); end
        wb_write(2'd2, 32'h1, 4'hF);
        set_value(30'd33, 4);
        set_value(30'd34, 4);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_thr0: got %b expected 0", irq); end
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h004) begin miscompares++; $display("FAIL irq_status: got %h expected %h", d, 32'h004); end
        wb_write(2'd2, 32'h3, 4'hF);
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h100) begin miscompares++; $display("FAIL irq_flush: got %h expected %h", d, 32'h100); end
    endtask

    task automatic test_wrap_flush();
        logic [31:0] d;
        set_value(30'h3FFF_FFFF, 4);
        set_value(30'd2, 4);
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h802) begin miscompares++; $display("FAIL wrap_status: got %h expected %h", d, 32'h802); end
        wb_write(2'd2, 32'h3, 4'hF);
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h900) begin miscompares++; $display("FAIL flush_status: got %h expected %h", d, 32'h900); end
    endtask

    task automatic test_bus_rules();
        logic [31:0] d;
        wb_read(2'd0, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL empty_read: got %h expected %h", d, 32'h0); end
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h900) begin miscompares++; $display("FAIL empty_status: got %h expected %h", d, 32'h900); end
        wb_write(2'd2, 32'hF0, 4'h3);
        wb_read(2'd2, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL partial_sel: got %h expected %h", d, 32'h1); end
        wb_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        wb_read(2'd3, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reserved: got %h expected %h", d, 32'h0); end
        @(negedge wb_clk_i);
        wbs_adr_i = BASE + 32'h20; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i); #1;
            vectors++;
            if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
                miscompares++; $display("FAIL nonhit[%0d]: got ack=%b dat=%h expected 0/0", i, wbs_ack_o, wbs_dat_o);
            end
        end
        wbs_adr_i = BASE + 32'h4;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i); #1;
            vectors++;
            if (wbs_ack_o !== ((i % 2) == 0)) begin
                miscompares++; $display("FAIL held_strobe[%0d]: got ack=%b expected %b", i, wbs_ack_o, (i % 2) == 0);
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wb_write(2'd2, 32'h31, 4'hF);
        @(negedge wb_clk_i);
        wbs_adr_i = BASE + 32'h4; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        reset = 1'b1;
        @(posedge wb_clk_i); #1;
        vectors++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            miscompares++; $display("FAIL reset_mid_ack: got ack=%b dat=%h expected 0/0", wbs_ack_o, wbs_dat_o);
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(posedge wb_clk_i); #1;
        reset = 1'b0;
        wb_read(2'd2, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_mid_ctrl: got %h expected %h", d, 32'h0); end
        wb_read(2'd1, d);
        vectors++;
        if (d !== 32'h100) begin miscompares++; $display("FAIL reset_mid_status: got %h expected %h", d, 32'h100); end
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_sequence();
        test_overflow();
        test_irq();
        test_wrap_flush();
        test_bus_rules();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fib_capture.md
# fib_capture

Downstream consumer of the 30-bit Fibonacci value bus, in the `wb_clk_i` domain. It detects each new settled value and pushes it into a small synchronous FIFO. The FIFO is drained through a Wishbone slave window, and an IRQ is raised when the fill level reaches a programmable threshold. It sits in the wrapper beside the Wishbone logic, taking `value` from the Fibonacci counter and returning `wbs_ack_o`/`wbs_dat_o`/`irq` for muxing.

## Interface
- `BASE_ADDRESS`, default 32'h3000_0100: window base; the block decodes 16 bytes.
- `WIDTH`, default 30: Fibonacci value width.
- `DEPTH`, default 8: FIFO entries; must be a power of 2, at most 16.
- `wb_clk_i`  in  1: the only clock.
- `reset`  in  1: synchronous, active-high; clears all state.
- `value`  in  WIDTH: Fibonacci output, quasi-static. It changes on divided-clock edges derived from `wb_clk_i`.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1: Wishbone classic strobe, cycle and write enable.
- `wbs_sel_i`  in  4: byte selects.
- `wbs_adr_i`  in  32: byte address.
- `wbs_dat_i`  in  32: write data.
- `wbs_ack_o`  out  1: registered single-cycle acknowledge.
- `wbs_dat_o`  out  32: registered read data.
- `irq`  out  1: level interrupt, registered.

## Operation
- **Address decode.** A request is a hit when `wbs_adr_i[31:4] == BASE_ADDRESS[31:4]`. The register offset is `wbs_adr_i[3:2]`:
  - 0 = DATA (read only). The read pops one entry and returns {2'b0, entry}. When the FIFO is empty the read returns 0 and does not pop.
  - 1 = STATUS (read only): [4:0] count, [8] empty, [9] full, [10] overflow (sticky), [11] wrap (sticky).
  - 2 = CTRL (read/write): [0] enable, [1] flush (write-1 pulse, reads 0), [2] clear sticky flags (write-1 pulse, reads 0), [7:4] irq threshold.
  - 3 = reserved: reads 0, writes ignored, still acked.
- **CTRL writes.** A CTRL write takes effect only when `wbs_sel_i == 4'hF`. Any other select pattern is acked and ignored.
- **Change detector.**
  - Registers: s1 <= `value`, s2 <= s1, plus `last`.
  - Push condition: enable && s1 == s2 && s2 != `last`. On a push, `last` <= s2.
  - Wrap flag: if a pushed s2 < `last`, set wrap. This indicates counter overflow or Fibonacci restart.
- **FIFO full.**
  - Push while full and no pop in the same cycle: the new value is dropped, overflow is set and `last` still updates.
  - Push and pop in the same cycle: both occur, count is unchanged, overflow is not set.
- **Flush.** Flush empties the FIFO (count = 0) and leaves sticky flags unchanged. If a push coincides with flush, flush wins: the push is discarded and `last` still updates.
- **Interrupt.** `irq` = (threshold != 0) && (count >= threshold), registered one cycle after count.
- **Disabled.** With enable = 0 there are no pushes. Pops still work. `last` holds its value.

## Timing
- **Reset values.**
  - Outputs: `wbs_ack_o` = 0, `wbs_dat_o` = 0, `irq` = 0.
  - Registers: count = 0, flags = 0, enable = 0, threshold = 0, s1 = s2 = `last` = 0.
  - Reset mid-transfer drops the pending ack.
- **Capture latency.** A value stable from edge k is registered in s1 at edge k and s2 at edge k+1, pushed at edge k+2, and visible in STATUS.count after edge k+2.
- **Wishbone request and ack.**
  - A hit with `wbs_stb_i & wbs_cyc_i` and `wbs_ack_o` = 0 is accepted at edge n.
  - `wbs_ack_o` = 1 and `wbs_dat_o` are valid for exactly the one cycle after edge n.
  - `wbs_ack_o` returns to 0 at edge n+1 even if the strobe is held, so back-to-back accesses are accepted every 2 cycles.
- **Side-effect timing.** The pop and any CTRL update occur at edge n. The read data reflects the pre-pop head.
- **Non-hits.** A non-hit is never acked, and `wbs_dat_o` stays 0.
- **Data bus.** `wbs_dat_o` returns to 0 when `wbs_ack_o` is 0.

## Structure
- Package `fib_capture_pkg`:
  - Register offset constants: OFF_DATA = 0, OFF_STATUS = 1, OFF_CTRL = 2.
  - STATUS and CTRL bit-position constants.
  - Default WIDTH and DEPTH.
- Sub-module `fib_fifo`: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, flush, din, dout (head, combinational from the register array), count, full, empty.
  - Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
- The top level holds the change detector, CTRL/flag registers, Wishbone decode and the irq register.

## Test plan
- **Reset and first capture.** Reset, write CTRL = 0x1, hold `value` = 5. Expect a push 2 cycles later, count = 1, and a DATA read returning 0x5 with count → 0.
- **Sequence capture.** Drive values 1,2,3,5,8, each held 4 cycles. Expect 5 entries read out in order. A repeated value held 20 cycles pushes only once.
- **Overflow.** Feed 9 distinct values with no reads. Expect full = 1, count = 8, overflow = 1, and the 9th value lost. Write CTRL = 0x5: overflow → 0, count stays 8.
- **IRQ threshold.** CTRL = 0x31 (threshold 3, enable). `irq` rises one cycle after count reaches 3, falls after one DATA read, and stays 0 while threshold = 0.
- **Wrap and flush.** Push 0x3FFF_FFFF, then 2. Expect wrap = 1. Write CTRL = 0x3: count = 0, wrap still 1.
- **Bus rules.**
  - Empty DATA read: returns 0, is acked, count stays 0.
  - CTRL write with sel = 4'h3: acked, no effect.
  - Address BASE+0x20: no ack.
  - Held strobe: ack pulses every 2nd cycle.
